// File: rtl/rename_pkg.sv
// Shared constants and types for the register alias table and its checkpoint buffer.
package rename_pkg;

  localparam int unsigned ARCH_ADDR_WIDTH = 5;
  localparam int unsigned NUM_ARCH_REGS   = 32;

  typedef logic [ARCH_ADDR_WIDTH-1:0] arch_addr_t;
  typedef arch_addr_t [NUM_ARCH_REGS-1:0] reset_map_t;

  function automatic int unsigned checkpoint_id_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic reset_map_t build_identity_map();
    reset_map_t m;
    for (int unsigned i = 0; i < NUM_ARCH_REGS; i++) begin
      m[i] = arch_addr_t'(i);
    end
    return m;
  endfunction

  // Architectural register i maps to physical register i out of reset.
  localparam reset_map_t IDENTITY_MAP = build_identity_map();

endpackage

// File: rtl/rename_map_table_checkpoint_buffer.sv
// Circular buffer of map snapshots with head/tail/count bookkeeping for mispredict recovery.
module map_checkpoint_buffer
  import rename_pkg::*;
#(
  parameter int unsigned PHYS_ADDR_WIDTH = 7,
  parameter int unsigned NUM_CHECKPOINTS = 4,
  localparam int unsigned CP_W = checkpoint_id_width(NUM_CHECKPOINTS)
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          create,
  input  logic                                          release_req,
  input  logic                                          restore_req,
  input  logic [CP_W-1:0]                               restore_id,
  input  logic [NUM_ARCH_REGS-1:0][PHYS_ADDR_WIDTH-1:0] create_map,
  output logic [NUM_ARCH_REGS-1:0][PHYS_ADDR_WIDTH-1:0] restore_map_c,
  output logic                                          restore_take_c,
  output logic [CP_W-1:0]                               tail_id,
  output logic                                          full
);

  localparam int unsigned CNT_W = CP_W + 1;

  typedef logic [NUM_ARCH_REGS-1:0][PHYS_ADDR_WIDTH-1:0] map_t;

  map_t             snapshot_q [NUM_CHECKPOINTS];
  logic [CP_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic             full_q;

  logic             release_ok_c, create_ok_c, restore_ok_c;
  logic [CP_W-1:0]  head_rel_c, restore_dist_c, tail_next_c;
  logic [CNT_W-1:0] count_rel_c, count_next_c;

  // Release retires the oldest entry first; restore is then judged against what remains.
  always_comb begin
    release_ok_c   = release_req && (count_q != '0);
    head_rel_c     = release_ok_c ? head_q + CP_W'(1) : head_q;
    count_rel_c    = count_q - CNT_W'(release_ok_c);
    restore_dist_c = restore_id - head_rel_c;
    restore_ok_c   = restore_req && ({1'b0, restore_dist_c} < count_rel_c);
    create_ok_c    = create && !restore_ok_c && (count_rel_c != CNT_W'(NUM_CHECKPOINTS));
    tail_next_c    = tail_q;
    count_next_c   = count_rel_c;
    if (restore_ok_c) begin
      tail_next_c  = restore_id;
      count_next_c = {1'b0, restore_dist_c};
    end else if (create_ok_c) begin
      tail_next_c  = tail_q + CP_W'(1);
      count_next_c = count_rel_c + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_rel_c;
      tail_q  <= tail_next_c;
      count_q <= count_next_c;
      full_q  <= (count_next_c == CNT_W'(NUM_CHECKPOINTS));
    end
  end

  // Snapshot storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (create_ok_c) begin
      snapshot_q[tail_q] <= create_map;
    end
  end

  assign restore_map_c  = snapshot_q[restore_id];
  assign restore_take_c = restore_ok_c;
  assign tail_id        = tail_q;
  assign full           = full_q;

endmodule

// File: rtl/rename_map_table.sv
// Register alias table: live arch->phys map, per-phys ready bits, lookup ports and checkpoint recovery.
module rename_map_table
  import rename_pkg::*;
#(
  parameter int unsigned PHYS_ADDR_WIDTH = 7,
  parameter int unsigned NUM_LOOKUPS     = 2,
  parameter int unsigned NUM_WB_PORTS    = 2,
  parameter int unsigned NUM_CHECKPOINTS = 4,
  localparam int unsigned CP_W = checkpoint_id_width(NUM_CHECKPOINTS)
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [NUM_LOOKUPS*ARCH_ADDR_WIDTH-1:0]  lookup_arch_addr,
  output logic [NUM_LOOKUPS*PHYS_ADDR_WIDTH-1:0]  lookup_phys_addr,
  output logic [NUM_LOOKUPS-1:0]                  lookup_ready,
  input  logic                                    rename_valid,
  input  logic [ARCH_ADDR_WIDTH-1:0]              rename_arch_addr,
  input  logic [PHYS_ADDR_WIDTH-1:0]              rename_phys_addr,
  output logic [PHYS_ADDR_WIDTH-1:0]              rename_old_phys_addr,
  input  logic [NUM_WB_PORTS-1:0]                 wb_valid,
  input  logic [NUM_WB_PORTS*PHYS_ADDR_WIDTH-1:0] wb_phys_addr,
  input  logic                                    checkpoint_create,
  output logic [CP_W-1:0]                         checkpoint_id,
  output logic                                    checkpoint_full,
  input  logic                                    checkpoint_release,
  input  logic                                    restore_valid,
  input  logic [CP_W-1:0]                         restore_id
);

  localparam int unsigned NUM_PHYS = 2 ** PHYS_ADDR_WIDTH;

  typedef logic [PHYS_ADDR_WIDTH-1:0] phys_addr_t;
  typedef phys_addr_t [NUM_ARCH_REGS-1:0] map_t;

  map_t                map_q, map_renamed_c, map_next_c, restore_map_c;
  logic [NUM_PHYS-1:0] ready_q, ready_next_c;
  logic                rename_en_c, restore_take_c;

  assign rename_en_c          = rename_valid && (rename_arch_addr != '0);
  assign rename_old_phys_addr = map_q[rename_arch_addr];

  // The snapshot captures the map including this cycle's rename.
  always_comb begin
    map_renamed_c = map_q;
    if (rename_en_c) begin
      map_renamed_c[rename_arch_addr] = rename_phys_addr;
    end
    map_next_c = restore_take_c ? restore_map_c : map_renamed_c;
  end

  // Writeback sets, a surviving rename clears (and wins), phys 0 is pinned ready.
  always_comb begin
    ready_next_c = ready_q;
    for (int unsigned j = 0; j < NUM_WB_PORTS; j++) begin
      if (wb_valid[j]) begin
        ready_next_c[wb_phys_addr[j*PHYS_ADDR_WIDTH +: PHYS_ADDR_WIDTH]] = 1'b1;
      end
    end
    if (rename_en_c && !restore_take_c) begin
      ready_next_c[rename_phys_addr] = 1'b0;
    end
    ready_next_c[0] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_ARCH_REGS; i++) begin
        map_q[i] <= phys_addr_t'(IDENTITY_MAP[i]);
      end
      ready_q <= '1;
    end else begin
      map_q   <= map_next_c;
      ready_q <= ready_next_c;
    end
  end

  // Source lookups with same-cycle writeback bypass; arch 0 is hardwired to phys 0.
  always_comb begin
    arch_addr_t lk_arch;
    phys_addr_t lk_phys;
    logic       lk_rdy;
    lookup_phys_addr = '0;
    lookup_ready     = '0;
    lk_arch          = '0;
    lk_phys          = '0;
    lk_rdy           = 1'b0;
    for (int unsigned k = 0; k < NUM_LOOKUPS; k++) begin
      lk_arch = lookup_arch_addr[k*ARCH_ADDR_WIDTH +: ARCH_ADDR_WIDTH];
      lk_phys = map_q[lk_arch];
      lk_rdy  = ready_q[lk_phys];
      for (int unsigned j = 0; j < NUM_WB_PORTS; j++) begin
        if (wb_valid[j] && (wb_phys_addr[j*PHYS_ADDR_WIDTH +: PHYS_ADDR_WIDTH] == lk_phys)) begin
          lk_rdy = 1'b1;
        end
      end
      if (lk_arch == '0) begin
        lk_phys = '0;
        lk_rdy  = 1'b1;
      end
      lookup_phys_addr[k*PHYS_ADDR_WIDTH +: PHYS_ADDR_WIDTH] = lk_phys;
      lookup_ready[k]                                        = lk_rdy;
    end
  end

  map_checkpoint_buffer #(
    .PHYS_ADDR_WIDTH (PHYS_ADDR_WIDTH),
    .NUM_CHECKPOINTS (NUM_CHECKPOINTS)
  ) u_checkpoints (
    .clock          (clock),
    .reset          (reset),
    .create         (checkpoint_create),
    .release_req    (checkpoint_release),
    .restore_req    (restore_valid),
    .restore_id     (restore_id),
    .create_map     (map_renamed_c),
    .restore_map_c  (restore_map_c),
    .restore_take_c (restore_take_c),
    .tail_id        (checkpoint_id),
    .full           (checkpoint_full)
  );

endmodule

// File: tb/tb_rename_map_table.sv
// Directed scoreboard bench for rename_map_table: stimulus queues expectations, a negedge monitor checks them.
module tb_rename_map_table;
  import rename_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  lookup_arch_addr;
  logic [13:0] lookup_phys_addr;
  logic [1:0]  lookup_ready;
  logic        rename_valid;
  logic [4:0]  rename_arch_addr;
  logic [6:0]  rename_phys_addr;
  logic [6:0]  rename_old_phys_addr;
  logic [1:0]  wb_valid;
  logic [13:0] wb_phys_addr;
  logic        checkpoint_create;
  logic [1:0]  checkpoint_id;
  logic        checkpoint_full;
  logic        checkpoint_release;
  logic        restore_valid;
  logic [1:0]  restore_id;

  rename_map_table #(
    .PHYS_ADDR_WIDTH (7),
    .NUM_LOOKUPS     (2),
    .NUM_WB_PORTS    (2),
    .NUM_CHECKPOINTS (4)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .lookup_arch_addr     (lookup_arch_addr),
    .lookup_phys_addr     (lookup_phys_addr),
    .lookup_ready         (lookup_ready),
    .rename_valid         (rename_valid),
    .rename_arch_addr     (rename_arch_addr),
    .rename_phys_addr     (rename_phys_addr),
    .rename_old_phys_addr (rename_old_phys_addr),
    .wb_valid             (wb_valid),
    .wb_phys_addr         (wb_phys_addr),
    .checkpoint_create    (checkpoint_create),
    .checkpoint_id        (checkpoint_id),
    .checkpoint_full      (checkpoint_full),
    .checkpoint_release   (checkpoint_release),
    .restore_valid        (restore_valid),
    .restore_id           (restore_id)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [6:0] p0;
    logic [6:0] p1;
    logic [1:0] rdy;
    logic [6:0] old;
    logic [1:0] id;
    logic       full;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input string field, input logic [6:0] act, input logic [6:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", name, field, act, expv);
    end
  endtask

  // Monitor: outputs are settled mid-cycle, so compare on the falling edge.
  always @(negedge clock) begin
    if (!reset && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "lookup_phys0", lookup_phys_addr[6:0], e.p0);
      chk(e.name, "lookup_phys1", lookup_phys_addr[13:7], e.p1);
      chk(e.name, "lookup_ready", 7'(lookup_ready), 7'(e.rdy));
      chk(e.name, "old_phys", rename_old_phys_addr, e.old);
      chk(e.name, "checkpoint_id", 7'(checkpoint_id), 7'(e.id));
      chk(e.name, "checkpoint_full", 7'(checkpoint_full), 7'(e.full));
    end
  end

  task automatic drive_idle();
    lookup_arch_addr   = '0;
    rename_valid       = 1'b0;
    rename_arch_addr   = '0;
    rename_phys_addr   = '0;
    wb_valid           = '0;
    wb_phys_addr       = '0;
    checkpoint_create  = 1'b0;
    checkpoint_release = 1'b0;
    restore_valid      = 1'b0;
    restore_id         = '0;
  endtask

  task automatic step(input string name, input logic [4:0] la0, input logic [4:0] la1,
                      input logic rv, input logic [4:0] ra, input logic [6:0] rp,
                      input logic [1:0] wbv, input logic [6:0] wb0, input logic [6:0] wb1,
                      input logic cc, input logic cr, input logic rsv, input logic [1:0] rsid,
                      input logic [6:0] e_p0, input logic [6:0] e_p1, input logic [1:0] e_rdy,
                      input logic [6:0] e_old, input logic [1:0] e_id, input logic e_full);
    exp_t e;
    @(posedge clock);
    #1;
    lookup_arch_addr   = {la1, la0};
    rename_valid       = rv;
    rename_arch_addr   = ra;
    rename_phys_addr   = rp;
    wb_valid           = wbv;
    wb_phys_addr       = {wb1, wb0};
    checkpoint_create  = cc;
    checkpoint_release = cr;
    restore_valid      = rsv;
    restore_id         = rsid;
    e.name = name; e.p0 = e_p0; e.p1 = e_p1; e.rdy = e_rdy;
    e.old = e_old; e.id = e_id; e.full = e_full;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive_idle();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    //   name                la0 la1  rv ra rp   wbv    wb0 wb1  cc cr rsv id  p0  p1  rdy    old id full
    step("reset_lookup",     5,  0,   0, 0, 0,   2'b00, 0,  0,   0, 0, 0, 0,  5,  0,  2'b11, 0,  0, 0);
    step("rename_3_40",      3,  0,   1, 3, 40,  2'b00, 0,  0,   0, 0, 0, 0,  3,  0,  2'b11, 3,  0, 0);
    step("lookup_3_after",   3,  0,   0, 0, 0,   2'b00, 0,  0,   0, 0, 0, 0,  40, 0,  2'b10, 0,  0, 0);
    step("wb_bypass_40",     3,  0,   0, 0, 0,   2'b01, 40, 0,   0, 0, 0, 0,  40, 0,  2'b11, 0,  0, 0);
    step("wb_kept_40",       3,  0,   0, 0, 0,   2'b00, 0,  0,   0, 0, 0, 0,  40, 0,  2'b11, 0,  0, 0);
    step("rename_arch0",     0,  3,   1, 0, 50,  2'b00, 0,  0,   0, 0, 0, 0,  0,  40, 2'b11, 0,  0, 0);
    step("arch0_kept",       0,  3,   0, 0, 0,   2'b00, 0,  0,   0, 0, 0, 0,  0,  40, 2'b11, 0,  0, 0);
    step("rename_4_41_cp",   4,  6,   1, 4, 41,  2'b00, 0,  0,   1, 0, 0, 0,  4,  6,  2'b11, 4,  0, 0);
    step("rename_4_42",      4,  6,   1, 4, 42,  2'b00, 0,  0,   0, 0, 0, 0,  41, 6,  2'b10, 41, 1, 0);
    step("rename_6_43",      4,  6,   1, 6, 43,  2'b00, 0,  0,   0, 0, 0, 0,  42, 6,  2'b10, 6,  1, 0);
    step("restore_0",        4,  6,   0, 0, 0,   2'b00, 0,  0,   0, 0, 1, 0,  42, 43, 2'b00, 0,  1, 0);
    step("restored_map",     4,  6,   0, 0, 0,   2'b01, 42, 0,   0, 0, 0, 0,  41, 6,  2'b10, 0,  0, 0);
    step("cp_a",             4,  6,   0, 0, 0,   2'b00, 0,  0,   1, 0, 0, 0,  41, 6,  2'b10, 0,  0, 0);
    step("cp_b",             4,  6,   0, 0, 0,   2'b00, 0,  0,   1, 0, 0, 0,  41, 6,  2'b10, 0,  1, 0);
    step("cp_c",             4,  6,   0, 0, 0,   2'b00, 0,  0,   1, 0, 0, 0,  41, 6,  2'b10, 0,  2, 0);
    step("cp_d",             4,  6,   0, 0, 0,   2'b00, 0,  0,   1, 0, 0, 0,  41, 6,  2'b10, 0,  3, 0);
    step("cp_drop",          4,  6,   0, 0, 0,   2'b00, 0,  0,   1, 0, 0, 0,  41, 6,  2'b10, 0,  0, 1);
    step("full_hold",        4,  6,   0, 0, 0,   2'b00, 0,  0,   0, 0, 0, 0,  41, 6,  2'b10, 0,  0, 1);
    step("create_release",   4,  6,   0, 0, 0,   2'b00, 0,  0,   1, 1, 0, 0,  41, 6,  2'b10, 0,  0, 1);
    step("wrapped",          4,  6,   0, 0, 0,   2'b00, 0,  0,   0, 0, 0, 0,  41, 6,  2'b10, 0,  1, 1);
    step("rename_6_44",      4,  6,   1, 6, 44,  2'b00, 0,  0,   0, 0, 0, 0,  41, 6,  2'b10, 6,  1, 1);
    step("restore_combo",    4,  6,   1, 4, 45,  2'b00, 0,  0,   1, 0, 1, 3,  41, 44, 2'b00, 41, 1, 1);
    step("after_combo",      4,  6,   0, 0, 0,   2'b00, 0,  0,   0, 0, 0, 0,  41, 6,  2'b10, 0,  3, 0);
    step("rename_6_46",      4,  6,   1, 6, 46,  2'b00, 0,  0,   0, 0, 0, 0,  41, 6,  2'b10, 6,  3, 0);
    step("restore_freed",    4,  6,   0, 0, 0,   2'b00, 0,  0,   0, 0, 1, 3,  41, 46, 2'b00, 0,  3, 0);
    step("freed_no_change",  4,  6,   0, 0, 0,   2'b00, 0,  0,   0, 0, 0, 0,  41, 46, 2'b00, 0,  3, 0);
    step("rename_wb_same",   7,  0,   1, 7, 47,  2'b01, 47, 0,   0, 0, 0, 0,  7,  0,  2'b11, 7,  3, 0);
    step("rename_wins",      7,  0,   0, 0, 0,   2'b00, 0,  0,   0, 0, 0, 0,  47, 0,  2'b10, 0,  3, 0);
    step("wb_two_ports",     7,  4,   0, 0, 0,   2'b11, 41, 47,  0, 0, 0, 0,  47, 41, 2'b11, 0,  3, 0);
    step("wb_both_set",      7,  4,   0, 0, 0,   2'b00, 0,  0,   0, 0, 0, 0,  47, 41, 2'b11, 0,  3, 0);
    step("rename_9_p0_cp",   9,  0,   1, 9, 0,   2'b00, 0,  0,   1, 0, 0, 0,  9,  0,  2'b11, 9,  3, 0);
    step("p0_ready_cp",      9,  0,   0, 0, 0,   2'b00, 0,  0,   1, 0, 0, 0,  0,  0,  2'b11, 0,  0, 0);

    // Asynchronous reset between clock edges, in the middle of activity.
    @(negedge clock);
    #1;
    reset = 1'b1;
    drive_idle();
    #2;
    reset = 1'b0;

    step("post_reset",       7,  4,   0, 0, 0,   2'b00, 0,  0,   0, 0, 0, 0,  7,  4,  2'b11, 0,  0, 0);
    step("post_reset_9",     9,  0,   0, 0, 0,   2'b00, 0,  0,   0, 0, 0, 0,  9,  0,  2'b11, 0,  0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations never checked, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
